// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registers ALU commands, captures results one cycle later into an in-order response FIFO
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_code,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alu_code,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [7:0]       alu_result,
  input  logic             alu_flag_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      cmd_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic {IDLE, EXEC} state_e;
  state_e state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [15:0] ccnt_q, ccnt_d;
  logic [7:0] res_mem [DEPTH];
  logic car_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic accept, wr, pop;
  assign cmd_ready = !rst && state_q == IDLE && cnt_q < FULL;
  assign accept = cmd_valid && cmd_ready;
  assign wr = state_q == EXEC;
  assign rsp_valid = cnt_q != '0;
  assign pop = rsp_valid && rsp_ready;
  assign rsp_result = rsp_valid ? res_mem[rptr_q] : '0;
  assign rsp_carry = rsp_valid ? car_mem[rptr_q] : 1'b0;
  assign rsp_tag = rsp_valid ? tag_mem[rptr_q] : '0;
  assign busy = wr || rsp_valid;
  assign alu_code = code_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign cmd_count = ccnt_q;
  always_comb begin
    state_d = accept ? EXEC : IDLE;
    code_d = accept ? cmd_code : code_q;
    a_d = accept ? cmd_a : a_q;
    b_d = accept ? cmd_b : b_q;
    tag_d = accept ? cmd_tag : tag_q;
    wptr_d = wr ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    cnt_d = cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
    ccnt_d = wr ? ccnt_q + 16'd1 : ccnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q <= '0;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      a_q <= a_d;
      b_q <= b_d;
      tag_q <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      ccnt_q <= ccnt_d;
    end
  end
  // the ALU flag is only meaningful for add/sub; logic ops leave it stale
  always_ff @(posedge clk) begin
    if (wr) begin
      res_mem[wptr_q] <= alu_result;
      car_mem[wptr_q] <= code_q[2:1] == 2'b00 && alu_flag_c;
      tag_mem[wptr_q] <= tag_q;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: queue-based reference model plus directed checks for alu_cmd_issuer
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  typedef struct packed {logic [7:0] r; logic c; logic [TAG_W-1:0] t;} ent_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_carry, busy, alu_flag_c;
  logic [2:0] cmd_code = 0, alu_code;
  logic [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b;
  logic [TAG_W-1:0] cmd_tag = 0, rsp_tag;
  logic [7:0] alu_result, rsp_result;
  logic [15:0] cmd_count;
  int tests = 0, fails = 0;
  ent_t q[$];
  ent_t pend;
  bit m_exec = 0;
  logic [15:0] m_cnt = 0;
  logic [2:0] m_code = 0;
  logic [3:0] m_a = 0, m_b = 0;
  logic [TAG_W-1:0] popped[$];

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_code(alu_code), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .alu_flag_c(alu_flag_c), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag),
    .busy(busy), .cmd_count(cmd_count));

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(logic [2:0] c, logic [3:0] a, logic [3:0] b);
    logic [7:0] x, y;
    x = {4'h0, a};
    y = {4'h0, b};
    case (c)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return {4'h0, ~(a & b)};
      3'd6: return {4'h0, ~(a | b)};
      default: return x ^ y;
    endcase
  endfunction

  // bench ALU: borrow on sub, and a deliberately stale 1 on every logic/mul op
  assign alu_result = alu_fn(alu_code, alu_a, alu_b);
  assign alu_flag_c = alu_code == 3'd1 ? alu_a < alu_b : alu_code != 3'd0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit rdy, pp, acc;
    if (rst) begin
      q.delete();
      m_exec = 0;
      m_cnt = 0;
      m_code = 0;
      m_a = 0;
      m_b = 0;
    end else begin
      rdy = !m_exec && q.size() < DEPTH;
      pp = q.size() != 0 && rsp_ready;
      acc = cmd_valid && rdy;
      if (pp) void'(q.pop_front());
      if (m_exec) begin
        q.push_back(pend);
        m_cnt++;
        m_exec = 0;
      end
      if (acc) begin
        m_code = cmd_code;
        m_a = cmd_a;
        m_b = cmd_b;
        pend = {alu_fn(cmd_code, cmd_a, cmd_b), cmd_code == 3'd1 && cmd_a < cmd_b, cmd_tag};
        m_exec = 1;
      end
    end
  end

  always @(negedge clk) begin
    ent_t h;
    h = q.size() != 0 ? q[0] : '0;
    chk("cmd_ready", cmd_ready, !rst && !m_exec && q.size() < DEPTH);
    chk("rsp_valid", rsp_valid, q.size() != 0);
    chk("rsp_result", rsp_result, h.r);
    chk("rsp_carry", rsp_carry, h.c);
    chk("rsp_tag", rsp_tag, h.t);
    chk("busy", busy, m_exec || q.size() != 0);
    chk("cmd_count", cmd_count, m_cnt);
    chk("alu_code", alu_code, m_code);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (!rst && rsp_valid && rsp_ready) popped.push_back(rsp_tag);
  end

  task automatic send(logic [2:0] c, logic [3:0] a, logic [3:0] b, logic [TAG_W-1:0] t);
    int n;
    @(negedge clk);
    cmd_valid = 1;
    cmd_code = c;
    cmd_a = a;
    cmd_b = b;
    cmd_tag = t;
    for (n = 0; n < 50; n++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (n == 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: tag %0h not accepted within 50 cycles", t);
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic pop1();
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_alu", {alu_code, alu_a, alu_b}, 0);
    rsp_ready = 1;
    send(3'd0, 4'd9, 4'd8, 4'd3);
    chk("add_alu", {alu_code, alu_a, alu_b}, {3'd0, 4'd9, 4'd8});
    chk("add_busy", busy, 1);
    chk("add_not_yet", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("add_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 8'h11);
    chk("add_carry", rsp_carry, 0);
    chk("add_tag", rsp_tag, 3);
    chk("add_count", cmd_count, 1);
    @(posedge clk);
    #1 chk("add_drained", busy, 0);
    rsp_ready = 0;
    send(3'd1, 4'h0, 4'h1, 4'd5);
    send(3'd3, 4'hC, 4'hA, 4'd6);
    send(3'd2, 4'hF, 4'hF, 4'd7);
    @(posedge clk);
    #1;
    chk("sub_result", rsp_result, 8'hFF);
    chk("sub_carry", rsp_carry, 1);
    pop1();
    chk("and_result", rsp_result, 8'h08);
    chk("and_carry", rsp_carry, 0);
    chk("and_tag", rsp_tag, 6);
    pop1();
    chk("mul_result", rsp_result, 8'hE1);
    chk("mul_carry", rsp_carry, 0);
    pop1();
    chk("logic_empty", rsp_valid, 0);
    chk("logic_count", cmd_count, 4);
    popped.delete();
    fork
      for (int i = 0; i < 5; i++) send(3'd7, 4'(i), 4'h5, 4'(i));
      begin
        repeat (14) @(negedge clk);
        chk("bp_ready_low", cmd_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_head_tag", rsp_tag, 0);
        @(posedge clk);
        #1 rsp_ready = 1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("bp_pop_count", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_order", popped[i], i);
    chk("bp_count", cmd_count, 9);
    rsp_ready = 0;
    popped.delete();
    send(3'd4, 4'd1, 4'd2, 4'd8);
    send(3'd4, 4'd3, 4'd4, 4'd9);
    @(posedge clk);
    #1;
    send(3'd6, 4'd5, 4'd6, 4'd10);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    chk("pw_head", rsp_tag, 9);
    chk("pw_popped", popped.size(), 1);
    rsp_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("pw_total", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++) chk("pw_order", popped[i], 8 + i);
    popped.delete();
    send(3'd0, 4'd2, 4'd3, 4'd11);
    #2 rst = 1;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", cmd_count, 0);
    chk("arst_alu", {alu_code, alu_a, alu_b}, 0);
    chk("arst_ready", cmd_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    send(3'd1, 4'd7, 4'd2, 4'd12);
    @(posedge clk);
    #1;
    chk("post_result", rsp_result, 8'h05);
    chk("post_tag", rsp_tag, 12);
    chk("post_count", cmd_count, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("post_popped", popped.size(), 1);
    if (popped.size() != 0) chk("post_no_lost_tag", popped[0], 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
